// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

   localparam int HEADER_BYTES = 4;
   localparam int WORD_BYTES   = 4;

   typedef enum logic [2:0] {
      RECV_SIZE,
      SETUP,
      RECV_WORD,
      ASSEMBLE,
      WRITE,
      DONE
   } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Boot-time loader: takes a length-prefixed little-endian image from the UART
// byte stream and writes it word by word into instruction memory.
module program_loader
   import program_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  uart_out_data,
   input  logic        uart_out_ready,
   output logic        uart_out_valid,
   output logic [31:0] inst_mem_in_addr,
   output logic [31:0] inst_mem_in_data,
   output logic        inst_mem_in_valid,
   input  logic        inst_mem_in_ready,
   output logic        completed
);

   loader_state_t state, state_next;

   logic        running;
   logic [1:0]  byte_idx;
   logic [31:0] size;
   logic [29:0] words_left;
   logic [31:0] addr;
   logic [31:0] data;
   logic        byte_take;
   logic        word_take;

   // running is a registered enable that keeps the handshake outputs low
   // while reset is held, without routing reset combinationally to outputs.
   assign uart_out_valid    = running && ((state == RECV_SIZE) || (state == RECV_WORD));
   assign inst_mem_in_valid = running && (state == WRITE);
   assign completed         = (state == DONE);
   assign inst_mem_in_addr  = addr;
   assign inst_mem_in_data  = data;

   assign byte_take = uart_out_valid && uart_out_ready;
   assign word_take = inst_mem_in_valid && inst_mem_in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RECV_SIZE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RECV_SIZE: begin
            if (byte_take && (byte_idx == 2'(HEADER_BYTES - 1))) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            state_next = ((size >> 2) == 32'd0) ? DONE : RECV_WORD;
         end
         RECV_WORD: begin
            if (byte_take && (byte_idx == 2'(WORD_BYTES - 1))) begin
               state_next = ASSEMBLE;
            end
         end
         ASSEMBLE: begin
            state_next = WRITE;
         end
         WRITE: begin
            if (word_take) begin
               state_next = (words_left == 30'd1) ? DONE : RECV_WORD;
            end
         end
         DONE: begin
            state_next = DONE;
         end
         default: begin
            state_next = RECV_SIZE;
         end
      endcase
   end

   // Datapath: byte packing, word count and write address. The byte index
   // wraps naturally after four bytes, so it is already 0 when a word starts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         running    <= 1'b0;
         byte_idx   <= 2'd0;
         size       <= 32'd0;
         words_left <= 30'd0;
         addr       <= BASE_ADDR;
         data       <= 32'd0;
      end else begin
         running <= 1'b1;
         if (byte_take) begin
            byte_idx <= byte_idx + 2'd1;
            if (state == RECV_SIZE) begin
               size[{byte_idx, 3'b000} +: 8] <= uart_out_data;
            end else begin
               data[{byte_idx, 3'b000} +: 8] <= uart_out_data;
            end
         end
         if (state == SETUP) begin
            words_left <= 30'(size >> 2);
            addr       <= BASE_ADDR;
            byte_idx   <= 2'd0;
         end
         if (word_take) begin
            addr       <= addr + 32'(WORD_BYTES);
            words_left <= words_left - 30'd1;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a queue-based image model.
module tb_program_loader;

   localparam int PH_NONE  = 0;
   localparam int PH_SETUP = 1;
   localparam int PH_RECV  = 2;
   localparam int PH_ASM   = 3;
   localparam int PH_WRITE = 4;
   localparam int PH_DONE  = 5;
   localparam int PH_HOLD  = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  uartData;
   logic        uartReady;
   logic        uartValid;
   logic [31:0] memAddr;
   logic [31:0] memData;
   logic        memValid;
   logic        memReady;
   logic        completed;

   int checks = 0;
   int errors = 0;

   program_loader dut (
      .clk               (clk),
      .reset             (reset),
      .uart_out_data     (uartData),
      .uart_out_ready    (uartReady),
      .uart_out_valid    (uartValid),
      .inst_mem_in_addr  (memAddr),
      .inst_mem_in_data  (memData),
      .inst_mem_in_valid (memValid),
      .inst_mem_in_ready (memReady),
      .completed         (completed)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Raise reset between edges and confirm the outputs drop without a clock.
   task automatic pulseResetCheck();
      #2 reset = 1'b1;
      #1;
      checkOutput("async_uart_valid", uartValid, 0);
      checkOutput("async_mem_valid", memValid, 0);
      checkOutput("async_completed", completed, 0);
   endtask

   task automatic resetDut();
      reset     = 1'b1;
      uartReady = 1'b0;
      memReady  = 1'b0;
      uartData  = 8'h00;
      repeat (2) @(negedge clk);
      checkOutput("in_reset_uart_valid", uartValid, 0);
      checkOutput("in_reset_mem_valid", memValid, 0);
      checkOutput("in_reset_completed", completed, 0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_uart_valid", uartValid, 1);
      checkOutput("post_reset_mem_valid", memValid, 0);
      checkOutput("post_reset_completed", completed, 0);
   endtask

   // Streams one image, modelling the expected writes and the handshake gaps.
   // abortAfter >= 0 asserts reset once that many bytes have been consumed.
   task automatic applyStimulus(input logic [31:0] sizeVal, input bit fixedPattern,
                                input bit randomReady, input int abortAfter);
      logic [7:0]  bytesQ[$];
      logic [31:0] expAddr[$];
      logic [31:0] expData[$];
      logic [31:0] word;
      int nWords;
      int phase;
      int consumed;
      int writes;
      int holdCycles;
      bit finished;
      bit aborted;
      bit heldOnce;

      nWords = int'(sizeVal >> 2);
      for (int b = 0; b < 4; b++) bytesQ.push_back(sizeVal[8*b +: 8]);
      for (int w = 0; w < nWords; w++) begin
         word = fixedPattern ? 32'hF0C3AA55 : $urandom;
         for (int b = 0; b < 4; b++) bytesQ.push_back(word[8*b +: 8]);
         expAddr.push_back(32'(4 * w));
         expData.push_back(word);
      end

      phase = PH_NONE; consumed = 0; writes = 0; holdCycles = 0;
      finished = 0; aborted = 0; heldOnce = 0;

      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         @(negedge clk);
         case (phase)
            PH_SETUP: begin
               checkOutput("setup_uart_valid", uartValid, 0);
               checkOutput("setup_mem_valid", memValid, 0);
               phase = (nWords == 0) ? PH_DONE : PH_RECV;
            end
            PH_ASM: begin
               checkOutput("assemble_uart_valid", uartValid, 0);
               checkOutput("assemble_mem_valid", memValid, 0);
               phase = PH_WRITE;
            end
            PH_WRITE: begin
               checkOutput("write_valid", memValid, 1);
               phase = PH_NONE;
            end
            PH_RECV: begin
               checkOutput("recv_uart_valid", uartValid, 1);
               phase = PH_NONE;
            end
            PH_DONE, PH_HOLD: begin
               checkOutput("done_completed", completed, 1);
               checkOutput("done_uart_valid", uartValid, 0);
               checkOutput("done_mem_valid", memValid, 0);
               holdCycles = (phase == PH_DONE) ? 0 : holdCycles + 1;
               phase = PH_HOLD;
               if (holdCycles >= 10) finished = 1;
            end
            default: ;
         endcase
         checkOutput("valids_exclusive", uartValid && memValid, 0);
         checkOutput("no_spurious_write", memValid && (expAddr.size() == 0), 0);

         uartReady = randomReady ? ($urandom_range(0, 3) != 0) : 1'b1;
         uartData  = (bytesQ.size() != 0) ? bytesQ[0] : 8'($urandom);
         if (uartValid && uartReady) begin
            checkOutput("byte_expected", bytesQ.size() != 0, 1);
            if (bytesQ.size() != 0) void'(bytesQ.pop_front());
            consumed++;
            if (consumed == 4) phase = PH_SETUP;
            else if (consumed > 4 && (consumed - 4) % 4 == 0) phase = PH_ASM;
         end

         if (randomReady) begin
            memReady = 1'($urandom_range(0, 1));
         end else if (memValid && !heldOnce) begin
            memReady = 1'b0;
            heldOnce = 1;
         end else begin
            memReady = 1'b1;
         end
         if (memValid && memReady && expAddr.size() != 0) begin
            checkOutput("write_addr", memAddr, expAddr.pop_front());
            checkOutput("write_data", memData, expData.pop_front());
            writes++;
            phase = (expAddr.size() == 0) ? PH_DONE : PH_RECV;
         end

         if (abortAfter >= 0 && consumed == abortAfter) begin
            pulseResetCheck();
            aborted  = 1;
            finished = 1;
         end
      end

      if (!aborted) begin
         checkOutput("finished_in_budget", finished, 1);
         checkOutput("write_count", writes, nWords);
      end
   endtask

   initial begin
      reset     = 1'b1;
      uartReady = 1'b0;
      memReady  = 1'b0;
      uartData  = 8'h00;

      resetDut();
      applyStimulus(32'd64, 1'b1, 1'b0, -1);
      @(negedge clk);
      pulseResetCheck();

      resetDut();
      applyStimulus(32'd0, 1'b0, 1'b0, -1);
      resetDut();
      applyStimulus(32'd5, 1'b0, 1'b0, -1);
      resetDut();
      applyStimulus(32'd3, 1'b0, 1'b1, -1);

      resetDut();
      applyStimulus(32'd64, 1'b0, 1'b1, 4 + 4 + 2);
      resetDut();
      applyStimulus(32'd12, 1'b0, 1'b1, -1);

      for (int r = 0; r < 6; r++) begin
         resetDut();
         applyStimulus(32'($urandom_range(0, 48)), 1'b0, 1'b1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
